// File: rtl/key_event_decoder_pkg.sv
// Shared types and cycle constants for the key gesture decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        GAP,
        PRESS2
    } keyState_t;

    // Defaults assume a 50 MHz clock
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_LONG_CYC    = 50_000_000;
    localparam int DEF_DBL_GAP_CYC = 15_000_000;
    localparam int DEF_REPEAT_CYC  = 10_000_000;

    localparam int TST_LONG_CYC    = 20;
    localparam int TST_DBL_GAP_CYC = 8;
    localparam int TST_REPEAT_CYC  = 5;

    function automatic logic isBusy(input keyState_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key level in, gesture event pulses out.
interface key_event_decoder_if;

    logic nKeyIn;
    logic ShortPulse;
    logic DoublePulse;
    logic LongPulse;
    logic RepeatPulse;
    logic KeyBusy;

    modport master (
        output nKeyIn,
        input  ShortPulse,
        input  DoublePulse,
        input  LongPulse,
        input  RepeatPulse,
        input  KeyBusy
    );

    modport slave (
        input  nKeyIn,
        output ShortPulse,
        output DoublePulse,
        output LongPulse,
        output RepeatPulse,
        output KeyBusy
    );

endinterface

// File: rtl/key_edge_det.sv
// Press/release edge decode for an active-low, debounced key level.
module key_edge_det (
    input  logic Clk,
    input  logic Rst,
    input  logic nKey,
    output logic keyPress,
    output logic keyRelease
);

    logic keyR;
    logic primed;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            keyR   <= 1'b1;
            primed <= 1'b0;
        end else begin
            keyR   <= nKey;
            primed <= 1'b1;
        end
    end

    // First edge after reset only seeds history: a key held through reset is not a press
    assign keyPress   = primed & keyR & ~nKey;
    assign keyRelease = primed & ~keyR & nKey;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies key gestures into short, double, long and auto-repeat pulses.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LONG_CYC    = DEF_LONG_CYC,
    parameter int DBL_GAP_CYC = DEF_DBL_GAP_CYC,
    parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
    input  logic Clk,
    input  logic Rst,
    key_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic keyPress;
    logic keyRelease;

    keyState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             shortPulse;
    logic             doublePulse;
    logic             longPulse;
    logic             repeatPulse;
    logic             keyBusy;

    key_edge_det edgeDet (
        .Clk        (Clk),
        .Rst        (Rst),
        .nKey       (bus.nKeyIn),
        .keyPress   (keyPress),
        .keyRelease (keyRelease)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shortPulse  <= 1'b0;
            doublePulse <= 1'b0;
            longPulse   <= 1'b0;
            repeatPulse <= 1'b0;
            keyBusy     <= 1'b0;
        end else begin
            shortPulse  <= 1'b0;
            doublePulse <= 1'b0;
            longPulse   <= 1'b0;
            repeatPulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (keyPress) begin
                        state   <= PRESS1;
                        keyBusy <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (keyRelease) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        longPulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Release beats a coincident repeat tick
                    if (keyRelease) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        keyBusy <= 1'b0;
                    end else if (cnt == REP_LAST) begin
                        cnt         <= '0;
                        repeatPulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (keyPress) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        shortPulse <= 1'b1;
                        keyBusy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESS2: begin
                    cnt <= '0;
                    if (keyRelease) begin
                        state       <= IDLE;
                        doublePulse <= 1'b1;
                        keyBusy     <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    keyBusy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ShortPulse  = shortPulse;
    assign bus.DoublePulse = doublePulse;
    assign bus.LongPulse   = longPulse;
    assign bus.RepeatPulse = repeatPulse;
    assign bus.KeyBusy     = keyBusy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures plus random press/release runs.
module tb_key_event_decoder;

    localparam int L = 20;
    localparam int G = 8;
    localparam int R = 5;

    localparam int M_IDLE   = 0;
    localparam int M_FIRST  = 1;
    localparam int M_HELD   = 2;
    localparam int M_WAIT   = 3;
    localparam int M_SECOND = 4;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    key_event_decoder_if bus ();

    key_event_decoder #(
        .CNT_W       (26),
        .LONG_CYC    (L),
        .DBL_GAP_CYC (G),
        .REPEAT_CYC  (R)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int tests = 0;
    int failed = 0;
    int k = 0;

    // Model: gesture phase plus timestamps of press start, release and long event
    int phase = M_IDLE;
    int tPress, tRel, tLong;
    bit prevLvl = 1'b1;
    bit seed = 1'b1;
    bit eS, eD, eL, eR, eB;

    int nS, nD, nL, nR;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d",
                   tag, k, obs, exp);
        end
    endtask

    task automatic modelStep(input bit cur);
        bit pr, rl;
        eS = 0; eD = 0; eL = 0; eR = 0;
        if (seed) begin
            seed = 0;
            prevLvl = cur;
        end else begin
            pr = prevLvl & ~cur;
            rl = ~prevLvl & cur;
            prevLvl = cur;
            case (phase)
                M_IDLE: if (pr) begin phase = M_FIRST; tPress = k; end
                M_FIRST:
                    if (rl) begin
                        phase = M_WAIT; tRel = k;
                    end else if (k - tPress == L) begin
                        eL = 1; phase = M_HELD; tLong = k;
                    end
                M_HELD:
                    if (rl) phase = M_IDLE;
                    else if ((k - tLong) % R == 0) eR = 1;
                M_WAIT:
                    if (pr) phase = M_SECOND;
                    else if (k - tRel == G) begin eS = 1; phase = M_IDLE; end
                M_SECOND: if (rl) begin eD = 1; phase = M_IDLE; end
                default: phase = M_IDLE;
            endcase
        end
        eB = (phase != M_IDLE);
    endtask

    task automatic drive(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            bus.nKeyIn = lvl;
            @(posedge Clk);
            #1;
            k++;
            modelStep(lvl);
            chk("short",  int'(bus.ShortPulse),  int'(eS));
            chk("double", int'(bus.DoublePulse), int'(eD));
            chk("long",   int'(bus.LongPulse),   int'(eL));
            chk("repeat", int'(bus.RepeatPulse), int'(eR));
            chk("busy",   int'(bus.KeyBusy),     int'(eB));
            chk("onehot", int'($countones({bus.ShortPulse, bus.DoublePulse,
                                           bus.LongPulse, bus.RepeatPulse}) <= 1), 1);
            nS += int'(bus.ShortPulse);
            nD += int'(bus.DoublePulse);
            nL += int'(bus.LongPulse);
            nR += int'(bus.RepeatPulse);
        end
    endtask

    task automatic clrCounts();
        nS = 0; nD = 0; nL = 0; nR = 0;
    endtask

    task automatic chkCounts(input string tag, input int s, input int d,
                             input int l, input int r);
        chk({tag, "_nshort"},  nS, s);
        chk({tag, "_ndouble"}, nD, d);
        chk({tag, "_nlong"},   nL, l);
        chk({tag, "_nrepeat"}, nR, r);
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_short"},  int'(bus.ShortPulse),  0);
        chk({tag, "_double"}, int'(bus.DoublePulse), 0);
        chk({tag, "_long"},   int'(bus.LongPulse),   0);
        chk({tag, "_repeat"}, int'(bus.RepeatPulse), 0);
        chk({tag, "_busy"},   int'(bus.KeyBusy),     0);
    endtask

    task automatic doReset();
        Rst = 1'b1;
        #1;
        chkZero("async_rst");
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        phase = M_IDLE;
        seed = 1'b1;
    endtask

    initial begin
        Rst = 1'b1;
        bus.nKeyIn = 1'b1;
        clrCounts();
        repeat (2) @(posedge Clk);
        #1;
        chkZero("reset");
        Rst = 1'b0;

        // Short press
        clrCounts();
        drive(1, 3);
        drive(0, 5);
        drive(1, 20);
        chkCounts("short", 1, 0, 0, 0);
        chk("short_idle_busy", int'(bus.KeyBusy), 0);

        // Double click
        clrCounts();
        drive(0, 4);
        drive(1, 3);
        drive(0, 4);
        drive(1, 12);
        chkCounts("dbl", 0, 1, 0, 0);

        // Long hold with four repeats
        clrCounts();
        drive(0, 41);
        drive(1, 12);
        chkCounts("hold", 0, 0, 1, 4);

        // Second press coincides with gap timeout
        clrCounts();
        drive(0, 3);
        drive(1, 8);
        drive(0, 3);
        drive(1, 12);
        chkCounts("gap_edge", 0, 1, 0, 0);

        // Release exactly at the long threshold
        clrCounts();
        drive(0, 20);
        drive(1, 15);
        chkCounts("long_edge", 1, 0, 0, 0);

        // Reset during hold with key still low
        clrCounts();
        drive(0, 25);
        doReset();
        clrCounts();
        drive(0, 10);
        chkCounts("rst_held", 0, 0, 0, 0);
        chk("rst_held_busy", int'(bus.KeyBusy), 0);
        drive(1, 3);
        drive(0, 5);
        drive(1, 20);
        chkCounts("rst_fresh", 1, 0, 0, 0);

        // Random gestures with occasional reset
        for (int g = 0; g < 60; g++) begin
            drive(0, int'($urandom_range(1, 45)));
            if ($urandom_range(0, 9) == 0) doReset();
            drive(1, int'($urandom_range(1, 14)));
        end
        drive(1, 30);
        chk("final_busy", int'(bus.KeyBusy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
